// File: rtl/fsm_walk_pkg.sv
// Shared ring-FSM definitions for the walker and the FSM checker.
//   ring_state_e : ring FSM states S0_0..S1_1
//   walk_state_e : walker phases
//   next_state   : ring successor
//   trig_idx     : index of the input bit that advances a given state
//   exp_out      : expected 2-bit FSM output for a state and input vector
package fsm_walk_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    S0_0 = 2'b00,
    S0_1 = 2'b01,
    S1_0 = 2'b10,
    S1_1 = 2'b11
  } ring_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_HOLD = 2'b01,
    W_STEP = 2'b10,
    W_DONE = 2'b11
  } walk_state_e;

  function automatic ring_state_e next_state(input ring_state_e s);
    case (s)
      S0_0:    return S0_1;
      S0_1:    return S1_0;
      S1_0:    return S1_1;
      default: return S0_0;
    endcase
  endfunction

  function automatic logic [1:0] trig_idx(input ring_state_e s);
    case (s)
      S0_0:    return 2'd2;
      S0_1:    return 2'd1;
      S1_0:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_out(input ring_state_e s, input logic [3:0] v);
    case (s)
      S0_0:    return {v[0], v[1]};
      S0_1:    return {v[3], v[2]};
      S1_0:    return {v[0], v[3]};
      default: return {v[1], v[2]};
    endcase
  endfunction

endpackage

// File: rtl/fsm_walk_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying filler input bits.
//   clk, rst   : clock, synchronous active-high reset (loads seed)
//   seed_load  : reload the seed at the next edge
//   advance    : shift one step at the next edge
//   vec_nxt_c  : low nibble of the value the register takes at the next edge
module fsm_walk_lfsr
  import fsm_walk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_load,
  input  logic       advance,
  output logic [3:0] vec_nxt_c
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  // Next value: seed load wins over advance.
  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      lfsr_d = {lfsr_q[6:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The walker registers fsm_in from the value the LFSR holds next cycle.
  assign vec_nxt_c = lfsr_d[3:0];

endmodule

// File: rtl/fsm_walk_gen.sv
// Stimulus generator and scoreboard walking the ring FSM through full laps.
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request (sampled in IDLE); laps/hold captured with it
//   fsm_in     : registered drive to the FSM input
//   fsm_out    : FSM output, compared every busy cycle
//   busy, done : run in progress / one-cycle end-of-run pulse
//   mismatch   : one-cycle pulse for a failed compare in the previous cycle
//   err_count  : saturating failed-compare count for the current run
//   exp_state  : model state of the ring FSM
module fsm_walk_gen
  import fsm_walk_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned M      = 2,
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned LAPS_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LAPS_W-1:0] laps,
  input  logic [HOLD_W-1:0] hold,
  output logic [N-1:0]      fsm_in,
  input  logic [M-1:0]      fsm_out,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        exp_state
);

  localparam int unsigned STEP_W = LAPS_W + 2;

  walk_state_e       st_q, st_d;
  ring_state_e       exp_q, exp_d, cur_s;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              accept;
  logic              go_hold, go_step;
  logic [3:0]        lfsr_vec;
  logic [3:0]        vec;
  logic [N-1:0]      fsm_in_d;
  logic              busy_d, done_d;
  logic [1:0]        exp_o;
  logic              cmp_fail;

  fsm_walk_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (accept),
    .advance   (busy),
    .vec_nxt_c (lfsr_vec)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= W_IDLE;
      exp_q     <= S0_0;
      steps_q   <= '0;
      hold_q    <= '0;
      hcnt_q    <= '0;
      fsm_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      st_q     <= st_d;
      exp_q    <= exp_d;
      steps_q  <= steps_d;
      hold_q   <= hold_d;
      hcnt_q   <= hcnt_d;
      fsm_in   <= fsm_in_d;
      busy     <= busy_d;
      done     <= done_d;
      mismatch <= cmp_fail;
      if (accept) begin
        err_count <= '0;
      end else if (cmp_fail && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  // Next-state: steps_q counts transitions not yet issued; hcnt_q counts
  // HOLD cycles remaining after the current one.
  always_comb begin
    st_d    = st_q;
    exp_d   = exp_q;
    steps_d = steps_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    accept  = 1'b0;
    go_hold = 1'b0;
    go_step = 1'b0;
    case (st_q)
      W_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          hold_d  = hold;
          exp_d   = S0_0;
          steps_d = {laps, 2'b00};
          if (laps == '0) begin
            st_d = W_DONE;
          end else if (hold != '0) begin
            go_hold = 1'b1;
          end else begin
            go_step = 1'b1;
          end
        end
      end
      W_HOLD: begin
        if (hcnt_q == '0) begin
          go_step = 1'b1;
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      W_STEP: begin
        if (steps_q == '0) begin
          st_d = W_DONE;
        end else if (hold_q != '0) begin
          go_hold = 1'b1;
        end else begin
          go_step = 1'b1;
        end
      end
      default: st_d = W_IDLE;
    endcase
    cur_s = exp_d;
    if (go_hold) begin
      st_d   = W_HOLD;
      hcnt_d = hold_d - HOLD_W'(1);
    end
    // exp_state moves on the edge that enters STEP.
    if (go_step) begin
      st_d    = W_STEP;
      steps_d = steps_d - STEP_W'(1);
      exp_d   = next_state(cur_s);
    end
  end

  // Outputs for the next cycle: vector forcing per phase.
  always_comb begin
    vec      = lfsr_vec;
    fsm_in_d = '0;
    busy_d   = (st_d == W_HOLD) || (st_d == W_STEP);
    done_d   = (st_d == W_DONE);
    if (st_d == W_HOLD) begin
      vec[trig_idx(exp_d)] = 1'b0;
      fsm_in_d[3:0]        = vec;
    end else if (st_d == W_STEP) begin
      // Fire the current trigger; keep the successor's trigger low so the
      // FSM moves exactly one state.
      vec[trig_idx(cur_s)] = 1'b1;
      vec[trig_idx(exp_d)] = 1'b0;
      fsm_in_d[3:0]        = vec;
    end
  end

  // Scoreboard compare against the model state of this cycle.
  always_comb begin
    exp_o    = exp_out(exp_q, fsm_in[3:0]);
    cmp_fail = busy && (fsm_out != M'(exp_o));
  end

  assign exp_state = exp_q;

endmodule

// File: tb/tb_fsm_walk_gen.sv
// Directed bench for fsm_walk_gen with a behavioural ring FSM on fsm_in/fsm_out.
module tb_fsm_walk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] laps;
  logic [7:0] hold;
  logic [3:0] fsm_in;
  logic [1:0] fsm_out;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [7:0] err_count;
  logic [1:0] exp_state;

  int checks   = 0;
  int failures = 0;

  logic       inv;
  logic [1:0] ref_s;
  logic [1:0] ref_eff;
  logic [1:0] ref_out;

  always #5 clk = ~clk;

  fsm_walk_gen #(
    .N(4), .M(2), .HOLD_W(8), .LAPS_W(8), .ERR_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .laps      (laps),
    .hold      (hold),
    .fsm_in    (fsm_in),
    .fsm_out   (fsm_out),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .err_count (err_count),
    .exp_state (exp_state)
  );

  function automatic logic [1:0] tb_trig(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd2;
      2'd1:    return 2'd1;
      2'd2:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tb_eo(input logic [1:0] s, input logic [3:0] v);
    case (s)
      2'd0:    return {v[0], v[1]};
      2'd1:    return {v[3], v[2]};
      2'd2:    return {v[0], v[3]};
      default: return {v[1], v[2]};
    endcase
  endfunction

  // Ring FSM: Mealy output of the state it is entering this cycle.
  always_comb begin
    ref_eff = fsm_in[tb_trig(ref_s)] ? 2'(ref_s + 2'd1) : ref_s;
    ref_out = tb_eo(ref_eff, fsm_in);
    fsm_out = inv ? ~ref_out : ref_out;
  end

  always_ff @(posedge clk) begin
    if (rst) ref_s <= 2'd0;
    else     ref_s <= ref_eff;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Present a start at a negedge; returns just after the accepting edge k.
  task automatic do_start(input logic [7:0] l, input logic [7:0] h);
    @(negedge clk);
    start = 1'b1;
    laps  = l;
    hold  = h;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy cycles on the way.
  task automatic wait_done(input string tag, input int limit, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk(tag, 32'd0, 32'd1);
  endtask

  logic [3:0] t1_vec [4];
  logic [1:0] t1_st  [4];
  logic       t7_busy [7];
  int nb;
  int j;

  initial begin
    t1_vec  = '{4'h5, 4'hA, 4'h4, 4'hB};
    t1_st   = '{2'd1, 2'd2, 2'd3, 2'd0};
    t7_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rst   = 1'b1;
    start = 1'b0;
    laps  = '0;
    hold  = '0;
    inv   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fsm_in", 32'(fsm_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_exp_state", 32'(exp_state), 32'd0);
    rst = 1'b0;

    // One lap, no hold: LFSR A5,4A,95,2A give vectors 5,A,4,B.
    do_start(8'd1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_fsm_in", 32'(fsm_in), 32'(t1_vec[i]));
      chk("t1_exp_state", 32'(exp_state), 32'(t1_st[i]));
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_fsm_in_end", 32'(fsm_in), 32'd0);
    chk("t1_err", 32'(err_count), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Two laps, hold 3: 3 HOLD cycles then a STEP, per transition.
    do_start(8'd2, 8'd3);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      j = i / 4;
      chk("t2_busy", 32'(busy), 32'd1);
      if (i == 0) chk("t2_first_vec", 32'(fsm_in), 32'h1);
      if (i % 4 == 3) begin
        chk("t2_step_trig", 32'(fsm_in[tb_trig(2'(j % 4))]), 32'd1);
        chk("t2_step_state", 32'(exp_state), 32'((j + 1) % 4));
      end else begin
        chk("t2_hold_trig", 32'(fsm_in[tb_trig(2'(j % 4))]), 32'd0);
        chk("t2_hold_state", 32'(exp_state), 32'(j % 4));
      end
    end
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_err", 32'(err_count), 32'd0);

    // Zero laps: immediate done, no busy.
    do_start(8'd0, 8'd5);
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_fsm_in", 32'(fsm_in), 32'd0);
    @(negedge clk);
    chk("t3_done_pulse", 32'(done), 32'd0);
    chk("t3_busy_after", 32'(busy), 32'd0);

    // Inverted FSM output: mismatch k+2..k+5.
    inv = 1'b1;
    do_start(8'd1, 8'd0);
    @(negedge clk);
    chk("t4_mismatch_k1", 32'(mismatch), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_mismatch", 32'(mismatch), 32'd1);
    end
    @(negedge clk);
    chk("t4_mismatch_end", 32'(mismatch), 32'd0);
    chk("t4_err", 32'(err_count), 32'd4);

    // Inverted, 70 laps: 280 failures saturate at 255.
    do_start(8'd70, 8'd0);
    wait_done("t5_timeout", 400, nb);
    chk("t5_busy_len", 32'(nb), 32'd280);
    chk("t5_err_sat", 32'(err_count), 32'd255);
    inv = 1'b0;

    // Reset mid-run at busy cycle 10.
    do_start(8'd3, 8'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_fsm_in", 32'(fsm_in), 32'd0);
    chk("t6_exp_state", 32'(exp_state), 32'd0);
    chk("t6_err", 32'(err_count), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
    end
    do_start(8'd1, 8'd0);
    wait_done("t6_timeout", 20, nb);
    chk("t6_rerun_len", 32'(nb), 32'd4);
    chk("t6_rerun_err", 32'(err_count), 32'd0);

    // Start held high: ignored while busy/done, re-arms in the IDLE cycle.
    @(negedge clk);
    start = 1'b1;
    laps  = 8'd1;
    hold  = 8'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t7_busy", 32'(busy), 32'(t7_busy[i]));
      if (i == 4) chk("t7_done", 32'(done), 32'd1);
    end
    chk("t7_rearm_vec", 32'(fsm_in), 32'h5);
    start = 1'b0;
    wait_done("t7_timeout", 20, nb);
    chk("t7_rerun_len", 32'(nb), 32'd3);
    chk("t7_err", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
